// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 3-stage pipeline hazard controller.
//   ctrl_state_t : sequencing states of pipe_ctrl (RUN / MEM_WAIT / ERR)
//   RS1_LSB, RS2_LSB, RD_LSB, REG_W : register-field positions in a 32-bit instruction
//   reg_field()  : extracts a 5-bit register index from an instruction word
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam int REG_W   = 5;

  function automatic logic [REG_W-1:0] reg_field(input logic [31:0] inst, input int lsb);
    return inst[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: writeback-to-EX operand forwarding compare (purely combinational).
// Ports:
//   ex_inst   in  32 : instruction in EX (supplies rs1, rs2)
//   wb_inst   in  32 : instruction in MEM/WB (supplies rd)
//   wb_reg_wr in  1  : MEM/WB instruction writes the register file
//   fwd_a     out 1  : operand A should take the writeback result
//   fwd_b     out 1  : operand B should take the writeback result
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [31:0] ex_inst,
  input  logic [31:0] wb_inst,
  input  logic        wb_reg_wr,
  output logic        fwd_a,
  output logic        fwd_b
);

  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;
  logic             wb_live;

  assign rs1 = reg_field(ex_inst, RS1_LSB);
  assign rs2 = reg_field(ex_inst, RS2_LSB);
  assign rd  = reg_field(wb_inst, RD_LSB);

  // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
  assign wb_live = wb_reg_wr && (rd != '0);

  assign fwd_a = wb_live && (rd == rs1);
  assign fwd_b = wb_live && (rd == rs2);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the IF | DE/EX | MEM/WB pipeline.
// Drives hold/flush of PC, preg_1 and preg_2, selects WB->EX forwarding and
// freezes the pipeline while a data-memory access waits for dm_ack.
// Optional feature macro: PIPE_CTRL_TIMEOUT_EN (wait counter + sticky ERR state);
// without it MEM_WAIT waits indefinitely and mem_err is tied to 0.
// Parameters: TIMEOUT (wait cycles before ERR), CNT_W (stall counter width).
// Ports:
//   clk, reset (sync, active-high)
//   ex_inst, wb_inst, wb_reg_wr : forwarding inputs
//   dm_req, dm_ack              : data-memory handshake for the MEM/WB access
//   br_taken                    : EX resolves a taken branch/jump
//   hold_pc, hold_preg_1, hold_preg_2, flush_preg_1, flush_preg_2 : pipeline controls
//   fwd_a, fwd_b                : operand forwarding selects
//   mem_err                     : sticky access timeout
//   stall_cnt                   : saturating count of frozen cycles
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ex_inst,
  input  logic [31:0]      wb_inst,
  input  logic             wb_reg_wr,
  input  logic             dm_req,
  input  logic             dm_ack,
  input  logic             br_taken,
  output logic             hold_pc,
  output logic             hold_preg_1,
  output logic             hold_preg_2,
  output logic             flush_preg_1,
  output logic             flush_preg_2,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("pipe_ctrl: TIMEOUT must be at least 1");
  end

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic        freeze;
  logic        fwd_a_raw;
  logic        fwd_b_raw;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`endif

  fwd_unit u_fwd (
    .ex_inst   (ex_inst),
    .wb_inst   (wb_inst),
    .wb_reg_wr (wb_reg_wr),
    .fwd_a     (fwd_a_raw),
    .fwd_b     (fwd_b_raw)
  );

  // Next state and freeze decision.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt = state;
    freeze    = 1'b0;
    unique case (state)
      RUN: begin
        // dm_ack without dm_req falls through here and is ignored.
        if (dm_req && !dm_ack) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dm_ack) begin
          state_nxt = RUN;
        end else begin
          freeze = 1'b1;
`ifdef PIPE_CTRL_TIMEOUT_EN
          if (wait_expired) state_nxt = ERR;
`endif
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Mealy pipeline controls. A taken branch seen while frozen is dropped here;
  // br_taken stays up while EX is held, so the release cycle flushes it.
  always_comb begin
    hold_pc      = 1'b0;
    hold_preg_1  = 1'b0;
    hold_preg_2  = 1'b0;
    flush_preg_1 = 1'b0;
    flush_preg_2 = 1'b0;
    fwd_a        = 1'b0;
    fwd_b        = 1'b0;
    if (reset) begin
      flush_preg_1 = 1'b1;
      flush_preg_2 = 1'b1;
    end else begin
      hold_pc      = freeze;
      hold_preg_1  = freeze;
      hold_preg_2  = freeze;
      flush_preg_1 = br_taken && !freeze;
      fwd_a        = fwd_a_raw;
      fwd_b        = fwd_b_raw;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (freeze && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if ((state != MEM_WAIT) && (state_nxt == MEM_WAIT)) begin
        wait_cnt <= '0;
      end else if ((state == MEM_WAIT) && !dm_ack) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (state_nxt == ERR) mem_err <= 1'b1;
    end
  end
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the 3-stage pipeline (IF | DE/EX | MEM/WB). Each cycle it drives the hold and flush controls of the PC, `preg_1` and `preg_2`, selects operand forwarding from the writeback stage into EX, and freezes the pipeline while a data-memory access awaits its acknowledge. It sits beside the datapath in the top level, with no datapath storage of its own.

## Interface
- `TIMEOUT`, default 16: cycles a memory access may wait for `dm_ack` before the error state.
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_inst` in 32: instruction in EX (`preg_1_inst`); rs1=[19:15], rs2=[24:20].
- `wb_inst` in 32: instruction in MEM/WB (`preg_2_inst`); rd=[11:7].
- `wb_reg_wr` in 1: `preg_2_reg_wr`.
- `dm_req` in 1: `preg_2_rd_en | preg_2_wr_en`; memory access in MEM/WB.
- `dm_ack` in 1: data memory completes the access this cycle.
- `br_taken` in 1: EX resolves a taken branch or jump.
- `hold_pc` out 1: PC keeps its value.
- `hold_preg_1` out 1: `preg_1` keeps its value.
- `hold_preg_2` out 1: `preg_2` keeps its value.
- `flush_preg_1` out 1: `preg_1` loads a bubble.
- `flush_preg_2` out 1: `preg_2` loads a bubble (drives `preg_2` stall/clear).
- `fwd_a`, `fwd_b` out 1 each: EX operand A/B takes the writeback result instead of the register file.
- `mem_err` out 1: sticky access timeout.
- `stall_cnt` out CNT_W: total frozen cycles.

## Operation
- States: RUN, MEM_WAIT, ERR. Reset goes to RUN.
- RUN, `dm_req & !dm_ack`: freeze this cycle, then go to MEM_WAIT.
- RUN, no request or request acknowledged: advance normally.
- MEM_WAIT, `dm_ack`: release this cycle, then go to RUN.
- MEM_WAIT, no ack: wait counter +1. When the counter reaches TIMEOUT-1 without ack, go to ERR.
- ERR: freeze permanently. `mem_err`=1. Only `reset` exits.
- Freeze means `hold_pc`=`hold_preg_1`=`hold_preg_2`=1 and both flushes 0. `stall_cnt` +1 per frozen cycle, saturating at all-ones.
- Taken branch while not frozen: `flush_preg_1`=1 for that cycle and `flush_preg_2`=0.
- Taken branch while frozen: ignored. It is re-evaluated in the release cycle, because `br_taken` stays asserted while EX is held.
- Forwarding: `fwd_a` = `wb_reg_wr` & (rd≠0) & (rd==rs1). `fwd_b` uses the same rule with rs2.
- Forwarding is evaluated in every state, including while frozen. For loads, the forwarded value is valid in the `dm_ack` cycle.
- Wait counter clears on every entry to MEM_WAIT.

## Timing
- All hold, flush and forward outputs are combinational from the current state and inputs (Mealy), with zero-cycle latency.
- The state, wait counter, `mem_err` and `stall_cnt` are registered.
- While `reset`=1: holds 0, `flush_preg_1`=`flush_preg_2`=1, `fwd_a`=`fwd_b`=0.
- After reset: state RUN, `mem_err`=0, `stall_cnt`=0, wait counter 0.
- A single-cycle access (ack in the same cycle as `dm_req`) costs 0 stall cycles.
- An access acked N cycles after the request costs N frozen cycles.
- `dm_ack` without `dm_req` in RUN is ignored.
- Reset mid-wait: returns to RUN on the next edge. The outstanding access is abandoned.

## Configuration
- `PIPE_CTRL_TIMEOUT_EN` defined: wait counter and ERR state present, `mem_err` behaves as above.
- Not defined: no wait counter and no ERR state; MEM_WAIT waits indefinitely for `dm_ack`. `mem_err` is tied to 0.

## Structure
- Package `pipe_pkg`:
  - `ctrl_state_t` enum: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2.
  - Field-position localparams: RS1_LSB, RS2_LSB, RD_LSB.
- Sub-module `fwd_unit` (purely combinational): rs1/rs2/rd compare producing `fwd_a`/`fwd_b`. Its only job is the compare; all sequencing stays in `pipe_ctrl`.

## Test plan
- Reset held 2 cycles -> both flushes 1, holds 0. After release: RUN, `stall_cnt`=0, `mem_err`=0.
- `wb_inst` rd=x5, `wb_reg_wr`=1, `ex_inst` rs1=x5, rs2=x0 -> `fwd_a`=1, `fwd_b`=0. Repeat with rd=x0 -> both 0.
- `dm_req`=1, `dm_ack` arriving 3 cycles later -> 3 frozen cycles with all holds 1, release on the ack cycle, `stall_cnt`=3.
- `br_taken`=1 in RUN -> `flush_preg_1`=1 for exactly that cycle. `br_taken`=1 during MEM_WAIT -> no flush until the ack cycle.
- With `PIPE_CTRL_TIMEOUT_EN` and TIMEOUT=4, `dm_req` held with no ack -> ERR, `mem_err`=1, holds remain 1 until `reset`.
- `stall_cnt` preloaded near all-ones (CNT_W=4), extended stall -> saturates at 15.
